// File: rtl/mips32_pkg.sv
// Opcode constants shared by the mips32 pipeline and its program loader,
// plus the loader state encoding.
`timescale 1ns/1ps
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  typedef enum logic [2:0] {
    LD_IDLE     = 3'd0,
    LD_REG_INIT = 3'd1,
    LD_LOAD     = 3'd2,
    LD_START    = 3'd3,
    LD_RUN      = 3'd4,
    LD_FAULT    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/mips32_loader_ctr.sv
// Saturating program-word counter; flags the last legal slot and the
// point where MAX_WORDS words have been taken.
`timescale 1ns/1ps
module mips32_loader_ctr
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              last,
  output logic              full
);

  // One extra bit so MAX_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] MAX_C  = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(MAX_WORDS - 1);

  logic [ADDR_W:0] cnt;

  assign full  = (cnt == MAX_C);
  assign last  = (cnt == LAST_C);
  assign count = cnt[ADDR_W-1:0];

  always_ff @(posedge clk1) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot path for the mips32 core: register init, program streaming, core release.
// Optional running checksum of loaded words: define MIPS32_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter int         MAX_WORDS      = 1024,
  parameter int         REG_INIT_COUNT = 31,
  parameter logic [5:0] HLT_OPCODE     = OP_HLT
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              core_init,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [2:0] IDLE     = LD_IDLE;
  localparam logic [2:0] REG_INIT = LD_REG_INIT;
  localparam logic [2:0] LOAD     = LD_LOAD;
  localparam logic [2:0] START    = LD_START;
  localparam logic [2:0] RUN      = LD_RUN;
  localparam logic [2:0] FAULT    = LD_FAULT;

  localparam logic [5:0] REG_N = 6'(REG_INIT_COUNT);

  logic [2:0]        state;
  logic [5:0]        reg_cnt;
  logic [ADDR_W-1:0] count;
  logic              last;
  logic              full;
  logic              fire;
  logic              is_hlt;
  logic              boot;

  assign in_ready = (state == LOAD) && !full;
  assign fire     = in_valid && in_ready;
  assign is_hlt   = (in_data[31:26] == HLT_OPCODE);
  assign boot     = (state == IDLE) && start;

  mips32_loader_ctr #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) u_ctr (
    .clk1  (clk1),
    .rst   (rst),
    .clear (boot),
    .inc   (fire),
    .count (count),
    .last  (last),
    .full  (full)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      reg_cnt   <= '0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      core_init <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      mem_we    <= 1'b0;
      core_init <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Register 0 is issued on the entry edge so REG_INIT lasts exactly REG_N cycles.
            if (REG_N == 6'd0) begin
              state <= LOAD;
            end else begin
              state     <= REG_INIT;
              reg_we    <= 1'b1;
              reg_addr  <= '0;
              reg_wdata <= '0;
              reg_cnt   <= 6'd1;
            end
          end
        end
        REG_INIT: begin
          if (reg_cnt == REG_N) begin
            state <= LOAD;
          end else begin
            reg_we    <= 1'b1;
            reg_addr  <= reg_cnt[4:0];
            reg_wdata <= {26'd0, reg_cnt};
            reg_cnt   <= reg_cnt + 6'd1;
          end
        end
        LOAD: begin
          if (fire) begin
            mem_we    <= 1'b1;
            mem_addr  <= count;
            mem_wdata <= in_data;
            // HLT wins over the word limit: a HLT in the final slot is a clean finish.
            if (is_hlt) begin
              state <= START;
            end else if (last) begin
              error <= 1'b1;
              state <= FAULT;
            end
          end
        end
        START: begin
          core_init <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          cpu_run <= 1'b1;
          done    <= 1'b1;
        end
        FAULT: begin
          error <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk1) begin
    if (rst || boot) begin
      sum <= '0;
    end else if (fire) begin
      sum <= sum + in_data;
    end
  end

  assign checksum = sum;
`else
  assign checksum = 32'h0;
`endif

endmodule
